opb_register_simulink2ppc: RTL

OPB slave register that carries a 32-bit value from fabric (Simulink) logic to the PowerPC: the read-direction companion of the PPC-to-Simulink software register. It captures `user_data_in` on each `user_valid` strobe and keeps a sticky new-data flag, an overflow flag and a capture counter, all readable over OPB. Software can freeze capture and clear the status through a control word. One instance sits per readable software register on the ROACH OPB bus.

---
 rtl/opb_register_simulink2ppc.sv | 113 +++++++++++
 1 files changed

// File: rtl/opb_register_simulink2ppc.sv
// OPB slave carrying a 32-bit fabric word to the PowerPC. Exposes the captured value,
// sticky new/overflow flags and a capture count, with a software freeze/clear control word.
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01001300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010013FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid,
  output logic                    user_ack
);

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;
  localparam logic [1:0] IDX_COUNT  = 2'd3;

  localparam string unused_family = C_FAMILY;

  logic        ack_q;
  logic        user_ack_q;
  logic [31:0] dbus_q;
  logic [31:0] data_q;
  logic [31:0] count_q;
  logic        new_q;
  logic        ovf_q;
  logic        freeze_q;

  logic        hit;
  logic        start;
  logic [1:0]  idx;
  logic        cap;
  logic        ctl_wr;
  logic        clr_wr;
  logic [31:0] rd_mux;
  logic        unused_inputs;

  assign hit   = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  // A held select can only start a new transfer once the previous ack has dropped.
  assign start = hit && !ack_q;
  assign idx   = OPB_ABus[28:29];

  assign cap    = user_valid && !freeze_q;
  assign ctl_wr = start && !OPB_RNW && (idx == IDX_CTRL) && OPB_BE[3];
  assign clr_wr = ctl_wr && OPB_DBus[30];

  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_DATA:   rd_mux = data_q;
      IDX_STATUS: rd_mux = {29'd0, freeze_q, ovf_q, new_q};
      IDX_CTRL:   rd_mux = {31'd0, freeze_q};
      IDX_COUNT:  rd_mux = count_q;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q      <= 1'b0;
      user_ack_q <= 1'b0;
      dbus_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      new_q      <= 1'b0;
      ovf_q      <= 1'b0;
      freeze_q   <= 1'b0;
    end else begin
      ack_q      <= start;
      user_ack_q <= start && OPB_RNW && (idx == IDX_DATA);
      dbus_q     <= (start && OPB_RNW) ? rd_mux : '0;

      if (ctl_wr) freeze_q <= OPB_DBus[31];
      if (cap)    data_q   <= user_data_in;

      // Clear is applied first so a coincident capture counts as the first one.
      if (clr_wr)   count_q <= cap ? 32'd1 : 32'd0;
      else if (cap) count_q <= count_q + 32'd1;

      // user_ack_q marks the DATA read's ack cycle; a capture there keeps new set.
      if (cap)                          new_q <= 1'b1;
      else if (clr_wr || user_ack_q)    new_q <= 1'b0;

      if (clr_wr)                                ovf_q <= 1'b0;
      else if (cap && new_q && !user_ack_q)      ovf_q <= 1'b1;
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign user_ack   = user_ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_inputs = ^{OPB_seqAddr, OPB_DBus[0:29], OPB_BE[0:2]};

endmodule
